lcd_msg_sequencer: RTL and testbench

//  Reads fixed-length text messages from the 2048x8 message ROM/BRAM (sync read, 1-cycle latency)
//  and streams them as LCD byte transfers: line-1 address cmd, 16 chars, line-2 address cmd, 16 chars.

---
 rtl/lcd_msg_sequencer_pkg.sv | 19 +
 rtl/lcd_msg_sequencer_refresh_timer.sv | 28 ++
 rtl/lcd_msg_sequencer.sv | 163 ++++++++++++++++
 tb/tb_lcd_msg_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_msg_sequencer_pkg.sv
// Shared LCD command bytes, default terminator and sequencer state encoding.
package lcd_msg_sequencer_pkg;

   localparam logic [7:0] CMD_LINE1     = 8'h80;
   localparam logic [7:0] CMD_LINE2     = 8'hC0;
   localparam logic [7:0] TERM_CHAR_DEF = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_CMD_L1       = 3'd1,
      S_FETCH        = 3'd2,
      S_WAIT         = 3'd3,
      S_EMIT         = 3'd4,
      S_CMD_L2       = 3'd5,
      S_FINISH       = 3'd6,
      S_REFRESH_WAIT = 3'd7
   } state_t;

endpackage

// File: rtl/lcd_msg_sequencer_refresh_timer.sv
// Idle-time counter for auto-refresh: expire is high on the last of CYCLES enabled cycles.
module lcd_msg_sequencer_refresh_timer #(
   parameter int CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = $clog2(CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + CNT_W'(1);
   end

   assign expire = enable && (count == LAST);

endmodule

// File: rtl/lcd_msg_sequencer.sv
// Streams a fixed-length message slot from sync-read memory to the LCD writer as
// line-1 cmd, chars, line-2 cmd, chars; optionally replays a refresh slot when idle.
module lcd_msg_sequencer
   import lcd_msg_sequencer_pkg::*;
#(
   parameter int         ADDR_W         = 11,
   parameter int         MSG_LEN        = 32,
   parameter int         LINE_LEN       = 16,
   parameter int         SEL_W          = 6,
   parameter int         REFRESH_CYCLES = 50_000_000,
   parameter int         REFRESH_SEL    = 1,
   parameter logic [7:0] TERM_CHAR      = TERM_CHAR_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [SEL_W-1:0]  msg_sel,
   input  logic              auto_refresh,
   output logic [ADDR_W-1:0] memory_addr,
   input  logic [7:0]        mem_data,
   output logic [7:0]        lcd_byte,
   output logic              lcd_rs,
   output logic              lcd_valid,
   input  logic              lcd_ready,
   output logic              busy,
   output logic              done
);

   localparam int OFS_W = $clog2(MSG_LEN);
   localparam int IDX_W = $clog2(MSG_LEN + 1);
   localparam logic [IDX_W-1:0]  IDX_END      = IDX_W'(MSG_LEN);
   localparam logic [IDX_W-1:0]  IDX_LINE2    = IDX_W'(LINE_LEN);
   localparam logic [ADDR_W-1:0] REFRESH_BASE = ADDR_W'(REFRESH_SEL) << OFS_W;

   state_t            state, state_d;
   logic [IDX_W-1:0]  idx, idx_d, idx_inc;
   logic [ADDR_W-1:0] base, base_d, addr_d, launch_base;
   logic [7:0]        byte_d;
   logic              rs_d, valid_d, phase, phase_d, launch, expire;

   lcd_msg_sequencer_refresh_timer #(
      .CYCLES (REFRESH_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != S_REFRESH_WAIT),
      .enable (state == S_REFRESH_WAIT),
      .expire (expire)
   );

   assign idx_inc = idx + IDX_W'(1);
   assign busy    = (state != S_IDLE) && (state != S_REFRESH_WAIT);
   assign done    = (state == S_FINISH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         base        <= '0;
         phase       <= 1'b0;
         memory_addr <= '0;
         lcd_byte    <= '0;
         lcd_rs      <= 1'b0;
         lcd_valid   <= 1'b0;
      end else begin
         state       <= state_d;
         idx         <= idx_d;
         base        <= base_d;
         phase       <= phase_d;
         memory_addr <= addr_d;
         lcd_byte    <= byte_d;
         lcd_rs      <= rs_d;
         lcd_valid   <= valid_d;
      end
   end

   always_comb begin
      state_d     = state;
      idx_d       = idx;
      base_d      = base;
      addr_d      = memory_addr;
      byte_d      = lcd_byte;
      rs_d        = lcd_rs;
      valid_d     = lcd_valid;
      phase_d     = 1'b0;
      launch      = 1'b0;
      launch_base = ADDR_W'(msg_sel) << OFS_W;

      case (state)
         S_IDLE: launch = start;

         // Line-2 cmd arrives with valid low so every handshake is followed by an idle cycle.
         S_CMD_L1, S_CMD_L2: begin
            if (!lcd_valid) begin
               byte_d  = (state == S_CMD_L1) ? CMD_LINE1 : CMD_LINE2;
               rs_d    = 1'b0;
               valid_d = 1'b1;
            end else if (lcd_ready) begin
               valid_d = 1'b0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            addr_d  = base + ADDR_W'(idx[OFS_W-1:0]);
            state_d = S_WAIT;
         end

         // Two cycles: the memory registers the new address, then its data is captured.
         S_WAIT: begin
            if (!phase) begin
               phase_d = 1'b1;
            end else if (mem_data == TERM_CHAR) begin
               state_d = S_FINISH;
            end else begin
               byte_d  = mem_data;
               rs_d    = 1'b1;
               valid_d = 1'b1;
               state_d = S_EMIT;
            end
         end

         S_EMIT: begin
            if (lcd_ready) begin
               valid_d = 1'b0;
               idx_d   = idx_inc;
               if (idx_inc == IDX_END)
                  state_d = S_FINISH;
               else if (idx_inc == IDX_LINE2)
                  state_d = S_CMD_L2;
               else
                  state_d = S_FETCH;
            end
         end

         S_FINISH: state_d = auto_refresh ? S_REFRESH_WAIT : S_IDLE;

         S_REFRESH_WAIT: begin
            if (start) begin
               launch = 1'b1;
            end else if (!auto_refresh) begin
               state_d = S_IDLE;
            end else if (expire) begin
               launch      = 1'b1;
               launch_base = REFRESH_BASE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Launch drives the line-1 cmd straight away for single-cycle start latency.
      if (launch) begin
         base_d  = launch_base;
         idx_d   = '0;
         byte_d  = CMD_LINE1;
         rs_d    = 1'b0;
         valid_d = 1'b1;
         state_d = S_CMD_L1;
      end
   end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Directed bench for lcd_msg_sequencer with a sync-read message memory model.
module tb_lcd_msg_sequencer;

   localparam int ADDR_W = 11;
   localparam int SEL_W  = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              start = 1'b0;
   logic              auto_refresh = 1'b0;
   logic              lcd_ready = 1'b1;
   logic [SEL_W-1:0]  msg_sel = '0;
   logic [ADDR_W-1:0] memory_addr;
   logic [7:0]        mem_data = 8'h00;
   logic [7:0]        lcd_byte;
   logic              lcd_rs, lcd_valid, busy, done;

   logic [7:0]        rom [0:2047];
   logic [8:0]        got_q[$];
   logic [8:0]        exp_q[$];
   logic [ADDR_W-1:0] addr_q[$];
   int                n_done = 0, n_unstable = 0, n_b2b = 0;
   int                n_chk = 0, n_pass = 0;
   logic              hold_prev = 1'b0, hs_prev = 1'b0;
   logic [8:0]        prev_out = '0;

   always #5 clk = ~clk;

   lcd_msg_sequencer #(
      .REFRESH_CYCLES (100),
      .REFRESH_SEL    (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .msg_sel      (msg_sel),
      .auto_refresh (auto_refresh),
      .memory_addr  (memory_addr),
      .mem_data     (mem_data),
      .lcd_byte     (lcd_byte),
      .lcd_rs       (lcd_rs),
      .lcd_valid    (lcd_valid),
      .lcd_ready    (lcd_ready),
      .busy         (busy),
      .done         (done)
   );

   always @(posedge clk) mem_data <= rom[memory_addr];

   // Records every handshake and watches hold-stability and the idle cycle after a handshake.
   always @(posedge clk) begin
      if (!reset) begin
         hold_prev <= 1'b0;
         hs_prev   <= 1'b0;
      end else begin
         if (hold_prev && (!lcd_valid || {lcd_rs, lcd_byte} !== prev_out)) n_unstable <= n_unstable + 1;
         if (hs_prev && lcd_valid) n_b2b <= n_b2b + 1;
         if (lcd_valid && lcd_ready) begin
            got_q.push_back({lcd_rs, lcd_byte});
            if (lcd_rs) addr_q.push_back(memory_addr);
         end
         if (done) n_done <= n_done + 1;
         hold_prev <= lcd_valid && !lcd_ready;
         hs_prev   <= lcd_valid && lcd_ready;
         prev_out  <= {lcd_rs, lcd_byte};
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic build_exp(input int slot);
      exp_q.delete();
      exp_q.push_back(9'h080);
      for (int i = 0; i < 32; i++) begin
         if (rom[slot*32 + i] == 8'hFF) break;
         if (i == 16) exp_q.push_back(9'h0C0);
         exp_q.push_back({1'b1, rom[slot*32 + i]});
      end
   endtask

   task automatic cmp_stream(input string tag, input int off, input int exp_len);
      int bad = 0;
      chk({tag, " length"}, 32'(got_q.size() - off), 32'(exp_len));
      for (int i = 0; i < exp_q.size(); i++)
         if (off + i >= got_q.size() || got_q[off + i] !== exp_q[i]) bad++;
      chk({tag, " bytes"}, 32'(bad), 0);
   endtask

   task automatic pulse_start(input logic [SEL_W-1:0] sel);
      msg_sel = sel;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget, input bit rnd);
      int n = 0;
      while (!done && n < budget) begin
         if (rnd) lcd_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      chk({tag, " done seen"}, 32'(n < budget), 1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int off, aoff, d0, bad, n;
      for (int i = 0; i < 2048; i++) rom[i] = 8'hFF;
      for (int i = 0; i < 16; i++) rom[i] = 8'(8'h41 + i);
      for (int i = 0; i < 15; i++) rom[16 + i] = 8'(8'h61 + i);
      for (int i = 0; i < 31; i++) rom[32 + i] = 8'(8'h30 + i);
      rom[63] = 8'h20;
      rom[64] = 8'h48; rom[65] = 8'h45; rom[66] = 8'h4C; rom[67] = 8'h4C; rom[68] = 8'h4F;

      reset = 1'b0;
      #1;
      chk("rst lcd_valid", 32'(lcd_valid), 0);
      chk("rst lcd_byte", 32'(lcd_byte), 0);
      chk("rst lcd_rs", 32'(lcd_rs), 0);
      chk("rst memory_addr", 32'(memory_addr), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // slot 0: terminator at index 31
      build_exp(0); off = got_q.size(); d0 = n_done;
      pulse_start(0);
      chk("t1 start latency valid", 32'(lcd_valid), 1);
      chk("t1 first byte", 32'({lcd_rs, lcd_byte}), 32'h080);
      chk("t1 busy", 32'(busy), 1);
      wait_done("t1", 1000, 0);
      @(negedge clk);
      chk("t1 done one cycle", 32'(done), 0);
      cmp_stream("t1", off, 33);
      chk("t1 line2 cmd", 32'(got_q[off + 17]), 32'h0C0);
      chk("t1 last char", 32'(got_q[off + 32]), 32'h16F);
      chk("t1 done pulses", 32'(n_done - d0), 1);

      // slot 1: full 32 chars
      build_exp(1); off = got_q.size(); aoff = addr_q.size(); d0 = n_done;
      pulse_start(1);
      wait_done("t2", 1000, 0);
      @(negedge clk);
      cmp_stream("t2", off, 34);
      chk("t2 last char", 32'(got_q[off + 33]), 32'h120);
      chk("t2 first addr", 32'(addr_q[aoff]), 32'h020);
      chk("t2 last addr", 32'(addr_q[aoff + 31]), 32'h03F);
      bad = 0;
      for (int i = 1; i < 32; i++) if (addr_q[aoff + i] !== addr_q[aoff + i - 1] + 1) bad++;
      chk("t2 addr contiguous", 32'(bad), 0);
      chk("t2 done pulses", 32'(n_done - d0), 1);

      // slot 1 again with random back-pressure
      off = got_q.size();
      pulse_start(1);
      wait_done("t3", 3000, 1);
      lcd_ready = 1'b1;
      @(negedge clk);
      cmp_stream("t3", off, 34);
      chk("t3 hold stable", 32'(n_unstable), 0);
      chk("t3 idle after handshake", 32'(n_b2b), 0);

      // auto-refresh replays slot 1 exactly 100 cycles after FINISH exit
      auto_refresh = 1'b1;
      pulse_start(0);
      wait_done("t4 first", 1000, 0);
      off = got_q.size();
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("t4 no early replay", 32'(lcd_valid), 0);
      chk("t4 waiting not busy", 32'(busy), 0);
      @(negedge clk);
      chk("t4 replay valid", 32'(lcd_valid), 1);
      chk("t4 replay cmd", 32'({lcd_rs, lcd_byte}), 32'h080);
      build_exp(1);
      wait_done("t4 replay", 1000, 0);
      @(negedge clk);
      cmp_stream("t4 replay", off, 34);
      repeat (10) @(negedge clk);
      auto_refresh = 1'b0;
      off = got_q.size(); d0 = n_done;
      repeat (200) @(negedge clk);
      chk("t4 cancel no bytes", 32'(got_q.size() - off), 0);
      chk("t4 cancel no done", 32'(n_done - d0), 0);
      chk("t4 cancel idle", 32'(busy), 0);

      // reset while char 9 waits for ready
      off = got_q.size();
      pulse_start(0);
      n = 0;
      while ((got_q.size() - off) < 9 && n < 500) begin @(negedge clk); n++; end
      lcd_ready = 1'b0;
      chk("t5 reached char 8", 32'(n < 500), 1);
      n = 0;
      while (!lcd_valid && n < 10) begin @(negedge clk); n++; end
      chk("t5 char 9 held", 32'({lcd_valid, lcd_rs, lcd_byte}), 32'h349);
      #2 reset = 1'b0;
      #1;
      chk("t5 reset valid", 32'(lcd_valid), 0);
      chk("t5 reset outputs", {lcd_rs, lcd_byte, memory_addr, busy, done}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      lcd_ready = 1'b1;
      @(negedge clk);
      build_exp(1); off = got_q.size();
      pulse_start(1);
      wait_done("t5 after", 1000, 0);
      @(negedge clk);
      cmp_stream("t5 after", off, 34);

      // start while busy is dropped
      build_exp(0); off = got_q.size(); d0 = n_done;
      pulse_start(0);
      repeat (5) @(negedge clk);
      pulse_start(1);
      wait_done("t6 busy", 1000, 0);
      repeat (60) @(negedge clk);
      cmp_stream("t6 busy", off, 33);
      chk("t6 busy done once", 32'(n_done - d0), 1);

      // start coincident with refresh expiry wins
      auto_refresh = 1'b1;
      pulse_start(2);
      wait_done("t6 pre", 1000, 0);
      off = got_q.size(); aoff = addr_q.size();
      repeat (100) @(posedge clk);
      @(negedge clk);
      msg_sel = 6'd2;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      chk("t6 coincident launch", 32'(lcd_valid), 1);
      build_exp(2);
      wait_done("t6 coincident", 1000, 0);
      auto_refresh = 1'b0;
      @(negedge clk);
      cmp_stream("t6 coincident", off, 6);
      chk("t6 coincident slot addr", 32'(addr_q[aoff]), 32'h040);
      chk("final hold stable", 32'(n_unstable), 0);
      chk("final idle after handshake", 32'(n_b2b), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
